// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scanner: 4x4 matrix keypad scanner with frame-based debounce      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   logic [3:0]       row_meta;
   logic [3:0]       row_sync;
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic [15:0]      frame_bits;
   logic             frame_done;
   logic             sample_now;

   assign sample_now = (div_cnt == DIV_LAST);
   assign col_out    = ~(4'b0001 << col_idx);

   // Sampling at the end of the slot leaves the synchronizer time to settle after the column switch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_meta   <= 4'hF;
         row_sync   <= 4'hF;
         div_cnt    <= '0;
         col_idx    <= '0;
         frame_bits <= '0;
         frame_done <= 1'b0;
      end else begin
         row_meta   <= row_in;
         row_sync   <= row_meta;
         frame_done <= sample_now && (col_idx == 2'd3);
         if (sample_now) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            for (int r = 0; r < 4; r++) begin
               frame_bits[{2'(r), col_idx}] <= ~row_sync[r];
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   logic [4:0] pop_cnt;
   logic [3:0] single_idx;
   logic       is_none;
   logic       is_single;

   always_comb begin
      pop_cnt    = '0;
      single_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (frame_bits[i]) begin
            pop_cnt    = pop_cnt + 5'd1;
            single_idx = 4'(i);
         end
      end
   end

   assign is_none   = (pop_cnt == 5'd0);
   assign is_single = (pop_cnt == 5'd1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       cand;
   logic [3:0]       cand_nx;
   logic [3:0]       code_nx;
   logic             valid_nx;

   assign cnt_inc  = (cnt == CNT_DONE) ? cnt : cnt + CNT_W'(1);
   assign key_held = (state == PRESSED) || (state == RELEASE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         cand      <= cand_nx;
         key_code  <= code_nx;
         key_valid <= valid_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cand_nx  = cand;
      code_nx  = key_code;
      valid_nx = 1'b0;
      if (frame_done) begin
         case (state)
            IDLE: begin
               if (is_single) begin
                  cand_nx  = single_idx;
                  cnt_nx   = CNT_W'(1);
                  state_nx = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (is_single && (single_idx == cand)) begin
                  cnt_nx = cnt_inc;
                  if (cnt_inc == CNT_DONE) begin
                     state_nx = PRESSED;
                     code_nx  = cand;
                     valid_nx = 1'b1;
                  end
               end else begin
                  // A different single key aborts the attempt; it is picked up fresh from IDLE.
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end
            end
            PRESSED: begin
               if (is_none) begin
                  state_nx = RELEASE;
                  cnt_nx   = CNT_W'(1);
               end
            end
            RELEASE: begin
               if (is_none) begin
                  if (cnt_inc == CNT_DONE) begin
                     state_nx = IDLE;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt_inc;
                  end
               end else begin
                  state_nx = PRESSED;
                  cnt_nx   = '0;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_scanner: frame-level bench for keypad_scanner                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_keypad_scanner;
   localparam int SCAN_DIV = 4;
   localparam int DS       = 3;
   localparam int FRAME    = 4 * SCAN_DIV;

   typedef struct {
      logic [15:0] keys;
      bit          v;
      logic [3:0]  code;
      bit          h;
   } vec_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys  = '0;
   int          cyc   = 0;
   int          checks = 0;
   int          errors = 0;
   int          npulse = 0;

   vec_t tbl[$];
   vec_t expq[$];

   bit         m_held;
   int         m_streak;
   int         m_cand;
   int         m_rel;
   logic [3:0] m_code;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   // Pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && (col_out[c] === 1'b0)) row_in[r] = 1'b0;
   end

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_streak = 0; m_cand = 0; m_rel = 0; m_code = '0;
   endtask

   // Per-frame reference: classify the pressed set, then apply the press/release rules.
   task automatic model_frame(input logic [15:0] f, output bit emit);
      int n = $countones(f);
      int k = 0;
      emit = 0;
      for (int i = 0; i < 16; i++) if (f[i]) k = i;
      if (m_held) begin
         m_rel = (n == 0) ? m_rel + 1 : 0;
         if (m_rel == DS) begin m_held = 0; m_rel = 0; end
      end else if (m_streak == 0) begin
         if (n == 1) begin m_cand = k; m_streak = 1; end
      end else if (n == 1 && k == m_cand) begin
         m_streak++;
         if (m_streak == DS) begin
            emit = 1; m_held = 1; m_code = 4'(k); m_streak = 0; m_rel = 0;
         end
      end else begin
         m_streak = 0;
      end
   endtask

   // Frame j is sampled from cycle 16j+2 to 16j+14; its FSM result is visible at cycle 16j+17.
   initial begin : monitor
      logic [15:0] samp = '0;
      vec_t        samp_exp;
      bit          samp_has = 0;
      bit          emit;
      logic [3:0]  ecol;
      forever begin
         @(negedge clk);
         if (!reset) begin
            ecol = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("col_out", col_out, ecol);
            if (key_valid === 1'b1) npulse++;
            if (cyc % FRAME == 8) begin
               samp     = keys;
               samp_has = (expq.size() > 0);
               if (samp_has) samp_exp = expq.pop_front();
            end
            if (cyc >= FRAME + 1 && cyc % FRAME == 1) begin
               model_frame(samp, emit);
               check("model_valid", key_valid, emit);
               check("model_code", key_code, m_code);
               check("model_held", key_held, m_held);
               if (samp_has) begin
                  check("tbl_valid", key_valid, samp_exp.v);
                  check("tbl_code", key_code, samp_exp.code);
                  check("tbl_held", key_held, samp_exp.h);
               end
            end else begin
               check("stray_valid", key_valid, 0);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic drive_frame(input logic [15:0] k);
      do @(negedge clk); while (reset || (cyc % FRAME != FRAME - 2));
      keys = k;
   endtask

   task automatic add(input logic [15:0] k, input bit v, input logic [3:0] c, input bit h, input int n);
      vec_t e;
      e.keys = k; e.v = v; e.code = c; e.h = h;
      for (int i = 0; i < n; i++) tbl.push_back(e);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_col", col_out, 4'b1110);
      check("rst_held", key_held, 0);
      check("rst_valid", key_valid, 0);
      check("rst_code", key_code, 0);
      model_reset();
      expq.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin : stim
      logic [15:0] cur;
      // clean press of key 9, held 10 frames
      add(16'h0200, 0, 0, 0, 2);
      add(16'h0200, 1, 9, 1, 1);
      add(16'h0200, 0, 9, 1, 7);
      add(16'h0000, 0, 9, 1, 2);
      add(16'h0000, 0, 9, 0, 2);
      // bouncing key 3
      for (int i = 0; i < 5; i++) begin
         add(16'h0008, 0, 9, 0, 1);
         add(16'h0000, 0, 9, 0, 1);
      end
      add(16'h0008, 0, 9, 0, 2);
      add(16'h0008, 1, 3, 1, 1);
      add(16'h0000, 0, 3, 1, 2);
      add(16'h0000, 0, 3, 0, 1);
      // keys 4 and 6 together, then 6 released
      add(16'h0050, 0, 3, 0, 2);
      add(16'h0010, 0, 3, 0, 2);
      add(16'h0010, 1, 4, 1, 1);
      add(16'h0000, 0, 4, 1, 2);
      add(16'h0000, 0, 4, 0, 1);
      // key 5 held, key 6 added, key 5 released
      add(16'h0020, 0, 4, 0, 2);
      add(16'h0020, 1, 5, 1, 1);
      add(16'h0060, 0, 5, 1, 2);
      add(16'h0040, 0, 5, 1, 2);
      add(16'h0000, 0, 5, 1, 2);
      add(16'h0000, 0, 5, 0, 1);
      // release glitch
      add(16'h0020, 0, 5, 0, 2);
      add(16'h0020, 1, 5, 1, 1);
      add(16'h0020, 0, 5, 1, 1);
      add(16'h0000, 0, 5, 1, 1);
      add(16'h0020, 0, 5, 1, 1);
      add(16'h0000, 0, 5, 1, 2);
      add(16'h0000, 0, 5, 0, 1);

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("init_col", col_out, 4'b1110);
      check("init_held", key_held, 0);
      check("init_valid", key_valid, 0);
      check("init_code", key_code, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive_frame(tbl[i].keys);
         expq.push_back(tbl[i]);
      end
      drive_frame(16'h0000);
      drive_frame(16'h0000);

      // reset while debouncing key 5
      drive_frame(16'h0020);
      drive_frame(16'h0020);
      drive_frame(16'h0020);
      repeat (7) @(negedge clk);
      reset_pulse();
      npulse = 0;
      repeat (5) drive_frame(16'h0020);
      check("pulses_after_rst1", npulse, 1);
      check("held_after_rst1", key_held, 1);

      // reset while key 5 is accepted and held
      reset_pulse();
      npulse = 0;
      repeat (5) drive_frame(16'h0020);
      check("pulses_after_rst2", npulse, 1);
      repeat (4) drive_frame(16'h0000);

      cur = '0;
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 7))
            0, 1, 2, 3: cur = cur;
            4:          cur = '0;
            5, 6:       cur = 16'h0001 << $urandom_range(0, 15);
            default:    cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         endcase
         drive_frame(cur);
      end
      repeat (3) drive_frame(cur);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
